// File: rtl/db_req_queue.sv
// db_req_queue
//   Queues single-cycle database requests from the packet parser and runs
//   them one at a time against the key-value lookup engine. Each popped
//   request produces exactly one reply pulse to the parser: either the
//   engine's response flag or, if the engine stays silent, a timeout reply
//   with an all-zero flag.
//
// Ports
//   clk156        rising-edge clock
//   eth_rst_n     asynchronous active-low reset
//   in_key/flag   request from the parser, sampled while in_valid=1
//   in_valid      request pulse (no backpressure; full queue drops)
//   out_valid     one-cycle reply pulse to the parser
//   out_flag      reply flag, held until the next reply
//   db_req_*      valid/ready request channel to the lookup engine
//   db_rsp_valid  response pulse from the engine, only honoured in WAIT
//   db_rsp_flag   response flag
//   drop_cnt      saturating count of requests dropped on a full queue
//   timeout_cnt   saturating count of transactions ended by timeout
//   busy          queue non-empty or a transaction in flight
module db_req_queue #(
  parameter int KEY_SIZE = 96,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                db_req_valid,
  input  logic                db_req_ready,
  output logic [KEY_SIZE-1:0] db_req_key,
  output logic [3:0]          db_req_flag,
  input  logic                db_rsp_valid,
  input  logic [3:0]          db_rsp_flag,
  output logic [7:0]          drop_cnt,
  output logic [7:0]          timeout_cnt,
  output logic                busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              EW       = KEY_SIZE + 4;
  localparam logic [AW:0]     FULL     = (AW+1)'(DEPTH);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [15:0]     timer;
  logic            rsp_hit, tmo_hit, pop, push, load;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The head entry stays in the queue until its transaction completes, so
  // count includes the request currently on the engine channel.
  always_comb begin
    rsp_hit = (state == WAIT) && db_rsp_valid;
    // A response in the timeout cycle wins over the timeout.
    tmo_hit = (state == WAIT) && !db_rsp_valid && (timer == TMO_LAST);
    pop     = rsp_hit || tmo_hit;
    push    = in_valid && ((count != FULL) || pop);
    // IDLE waits out the reply cycle before loading the next head, which
    // gives the 4-cycle minimum spacing between engine requests.
    load    = (state == IDLE) && (count != '0) && !out_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = REQ;
      REQ:     if (db_req_ready) state_nxt = WAIT;
      WAIT:    if (pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign db_req_valid = (state == REQ);
  assign busy         = (count != '0) || (state != IDLE);

  // Queue storage: written on push only, deliberately not reset.
  always_ff @(posedge clk156) begin
    if (push) mem[wr_ptr] <= {in_key, in_flag};
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      timer       <= '0;
      out_valid   <= 1'b0;
      out_flag    <= 4'b0000;
      db_req_key  <= '0;
      db_req_flag <= 4'b0000;
      drop_cnt    <= 8'd0;
      timeout_cnt <= 8'd0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (state == REQ && db_req_ready) timer <= '0;
      else if (state == WAIT)           timer <= timer + 16'd1;

      if (load) {db_req_key, db_req_flag} <= mem[rd_ptr];

      out_valid <= pop;
      if (rsp_hit)      out_flag <= db_rsp_flag;
      else if (tmo_hit) out_flag <= 4'b0000;

      if (in_valid && !push) drop_cnt    <= sat_inc(drop_cnt);
      if (tmo_hit)           timeout_cnt <= sat_inc(timeout_cnt);
    end
  end

endmodule

// File: tb/tb_db_req_queue.sv
module tb_db_req_queue;

  logic        clk156 = 1'b0;
  logic        eth_rst_n;
  logic [95:0] in_key;
  logic [3:0]  in_flag;
  logic        in_valid;
  logic        out_valid;
  logic [3:0]  out_flag;
  logic        db_req_valid;
  logic        db_req_ready;
  logic [95:0] db_req_key;
  logic [3:0]  db_req_flag;
  logic        db_rsp_valid;
  logic [3:0]  db_rsp_flag;
  logic [7:0]  drop_cnt;
  logic [7:0]  timeout_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  db_req_queue #(.KEY_SIZE(96), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n),
    .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
    .out_valid(out_valid), .out_flag(out_flag),
    .db_req_valid(db_req_valid), .db_req_ready(db_req_ready),
    .db_req_key(db_req_key), .db_req_flag(db_req_flag),
    .db_rsp_valid(db_rsp_valid), .db_rsp_flag(db_rsp_flag),
    .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt), .busy(busy)
  );

  always #5 clk156 = ~clk156;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk156);
    #1;
  endtask

  function automatic logic [95:0] mk_key(input int i);
    return {32'hDB00_0000 + 32'(i), 32'hC0FF_EE00 + 32'(i), 32'h0000_1000 + 32'(i)};
  endfunction

  task automatic push(input logic [95:0] k, input logic [3:0] f);
    in_valid = 1'b1;
    in_key   = k;
    in_flag  = f;
    step();
    in_valid = 1'b0;
  endtask

  // Bounded wait for db_req_valid; returns the number of cycles waited.
  task automatic wait_req(output int n);
    n = 0;
    while (!db_req_valid && n < 20) begin
      step();
      n++;
    end
    chk("req_vld", db_req_valid, 1);
  endtask

  // Full transaction with db_req_ready=1 and an immediate response.
  task automatic do_txn(input logic [95:0] k, input logic [3:0] f,
                        input logic [3:0] rf, output int n);
    wait_req(n);
    chk("req_key", db_req_key, k);
    chk("req_flag", db_req_flag, f);
    step();
    db_rsp_valid = 1'b1;
    db_rsp_flag  = rf;
    step();
    db_rsp_valid = 1'b0;
    chk("rsp_out_vld", out_valid, 1);
    chk("rsp_out_flag", out_flag, rf);
    step();
    chk("rsp_out_pulse", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;
    logic [95:0] k;
    eth_rst_n    = 1'b0;
    in_key       = '0;
    in_flag      = '0;
    in_valid     = 1'b0;
    db_req_ready = 1'b0;
    db_rsp_valid = 1'b0;
    db_rsp_flag  = '0;
    step();
    step();
    chk("rst_out_vld", out_valid, 0);
    chk("rst_out_flag", out_flag, 0);
    chk("rst_req_vld", db_req_valid, 0);
    chk("rst_req_key", db_req_key, 0);
    chk("rst_req_flag", db_req_flag, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_tmo", timeout_cnt, 0);
    chk("rst_busy", busy, 0);
    eth_rst_n = 1'b1;
    step();

    // Single request, response in the third WAIT cycle.
    db_req_ready = 1'b1;
    k = 96'h0A000001_0A000002_0035_0000;
    push(k, 4'b0101);
    chk("s_t1_vld", db_req_valid, 0);
    chk("s_t1_busy", busy, 1);
    step();
    chk("s_t2_vld", db_req_valid, 1);
    chk("s_t2_key", db_req_key, k);
    chk("s_t2_flag", db_req_flag, 4'b0101);
    step();
    chk("s_wait_vld", db_req_valid, 0);
    step();
    step();
    db_rsp_valid = 1'b1;
    db_rsp_flag  = 4'b0100;
    step();
    db_rsp_valid = 1'b0;
    chk("s_out_vld", out_valid, 1);
    chk("s_out_flag", out_flag, 4'b0100);
    step();
    chk("s_out_pulse", out_valid, 0);
    chk("s_out_hold", out_flag, 4'b0100);
    chk("s_busy_end", busy, 0);

    // Backpressure for 10 cycles.
    db_req_ready = 1'b0;
    k = mk_key(100);
    push(k, 4'b0011);
    step();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!db_req_valid || db_req_key !== k || db_req_flag !== 4'b0011) bad = 1'b1;
      step();
    end
    chk("bp_stable", bad, 0);
    chk("bp_still_req", db_req_valid, 1);
    db_req_ready = 1'b1;
    step();
    chk("bp_wait_vld", db_req_valid, 0);
    chk("bp_wait_busy", busy, 1);
    db_rsp_valid = 1'b1;
    db_rsp_flag  = 4'b0010;
    step();
    db_rsp_valid = 1'b0;
    chk("bp_out_vld", out_valid, 1);
    chk("bp_out_flag", out_flag, 4'b0010);

    // Overflow: 10 pulses into a depth-8 queue with the engine stalled.
    db_req_ready = 1'b0;
    step();
    for (int i = 0; i < 10; i++) push(mk_key(i), 4'(i));
    chk("ov_drop", drop_cnt, 2);
    chk("ov_busy", busy, 1);
    db_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_txn(mk_key(i), 4'(i), ~4'(i), n);
      if (i > 0) chk("ov_gap", n, 1);
    end
    chk("ov_drop_end", drop_cnt, 2);
    chk("ov_busy_end", busy, 0);

    // Timeout with a late response, then the next entry proceeds.
    push(mk_key(40), 4'b0001);
    push(mk_key(41), 4'b0111);
    wait_req(n);
    chk("to_key", db_req_key, mk_key(40));
    step();
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    chk("to_early", bad, 0);
    step();
    chk("to_out_vld", out_valid, 1);
    chk("to_out_flag", out_flag, 4'b0000);
    chk("to_cnt", timeout_cnt, 1);
    db_rsp_valid = 1'b1;
    db_rsp_flag  = 4'b1111;
    step();
    db_rsp_valid = 1'b0;
    chk("to_late_vld", out_valid, 0);
    chk("to_late_flag", out_flag, 4'b0000);
    do_txn(mk_key(41), 4'b0111, 4'b1010, n);
    chk("to_cnt_after", timeout_cnt, 1);

    // Response lands in the timeout cycle.
    push(mk_key(50), 4'b1000);
    wait_req(n);
    step();
    for (int i = 0; i < 15; i++) step();
    db_rsp_valid = 1'b1;
    db_rsp_flag  = 4'b0110;
    step();
    db_rsp_valid = 1'b0;
    chk("col_out_vld", out_valid, 1);
    chk("col_out_flag", out_flag, 4'b0110);
    chk("col_tmo", timeout_cnt, 1);
    step();

    // Push into a full queue in the same cycle as a pop.
    db_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(mk_key(60 + i), 4'(i));
    chk("fp_drop_fill", drop_cnt, 2);
    db_req_ready = 1'b1;
    wait_req(n);
    chk("fp_key0", db_req_key, mk_key(60));
    step();
    db_rsp_valid = 1'b1;
    db_rsp_flag  = 4'b0011;
    in_valid     = 1'b1;
    in_key       = mk_key(68);
    in_flag      = 4'b1000;
    step();
    db_rsp_valid = 1'b0;
    in_valid     = 1'b0;
    chk("fp_out_vld", out_valid, 1);
    chk("fp_drop", drop_cnt, 2);
    step();
    for (int i = 1; i < 9; i++) do_txn(mk_key(60 + i), 4'(i), 4'(i + 3), n);
    chk("fp_busy_end", busy, 0);

    // Reset while in WAIT with 3 entries queued.
    push(mk_key(80), 4'b0001);
    push(mk_key(81), 4'b0010);
    push(mk_key(82), 4'b0011);
    step();
    step();
    db_rsp_valid = 1'b1;
    db_rsp_flag  = 4'b1100;
    eth_rst_n    = 1'b0;
    #1;
    chk("ar_out_vld", out_valid, 0);
    chk("ar_out_flag", out_flag, 0);
    chk("ar_req_vld", db_req_valid, 0);
    chk("ar_req_key", db_req_key, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_tmo", timeout_cnt, 0);
    chk("ar_busy", busy, 0);
    step();
    step();
    step();
    eth_rst_n    = 1'b1;
    db_rsp_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid || busy || db_req_valid) bad = 1'b1;
    end
    chk("ar_quiet", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/db_req_queue.md
# db_req_queue

Request buffer and transaction sequencer between the packet parser's database-request outputs (`in_key`/`in_flag`/`in_valid`) and the key-value lookup engine.
- The parser emits single-cycle request pulses with no backpressure. This block queues them, issues them one at a time over a valid/ready request channel, and waits for each response.
- It returns the result to the parser as a one-cycle `out_valid`/`out_flag` pulse.
- A lost response is converted into a timeout reply so the parser never stalls.

## Interface
Parameters:
- `KEY_SIZE`, 96, key width in bits.
- `DEPTH`, 8, queue entries; power of two, 2..64.
- `TIMEOUT`, 1024, cycles to wait for a response after handshake; 2..65535.

Ports:
- `clk156`  in  1  the single clock; all logic is on its rising edge.
- `eth_rst_n`  in  1  reset, asynchronous, active-low.
- `in_key`  in  KEY_SIZE  request key, sampled when `in_valid`=1.
- `in_flag`  in  4  request opcode, sampled when `in_valid`=1.
- `in_valid`  in  1  request pulse; there is no ready signal.
- `out_valid`  out  1  one-cycle reply pulse to the parser.
- `out_flag`  out  4  reply flag; bits [2:1]=2'b10 means block/filter.
- `db_req_valid`  out  1  request channel valid.
- `db_req_ready`  in  1  request channel ready.
- `db_req_key`  out  KEY_SIZE  request key.
- `db_req_flag`  out  4  request opcode.
- `db_rsp_valid`  in  1  response pulse from the engine.
- `db_rsp_flag`  in  4  response flag.
- `drop_cnt`  out  8  requests dropped because the queue was full; saturates at 255.
- `timeout_cnt`  out  8  transactions ended by timeout; saturates at 255.
- `busy`  out  1  1 when the queue is non-empty or the FSM is not in IDLE.

## Operation
- Queue:
  - FIFO of DEPTH entries of {key, flag}, with write/read pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Push occurs when `in_valid`=1 and (count<DEPTH or a pop happens in the same cycle).
  - When `in_valid`=1, count==DEPTH and there is no pop in that cycle, the request is discarded and `drop_cnt` increments.
  - A simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If count>0, load the head entry into the `db_req_key`/`db_req_flag` registers and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `db_req_valid`=1. Key and flag are held stable until the handshake.
  - On `db_req_valid`&&`db_req_ready`, go to WAIT and clear the timer.
- WAIT:
  - Timer (16-bit) increments each cycle.
  - If `db_rsp_valid`=1: register `out_flag`<=`db_rsp_flag`, `out_valid`<=1, pop the head, go to IDLE.
  - Else if timer==TIMEOUT-1: `out_flag`<=4'b0000, `out_valid`<=1, pop, increment `timeout_cnt`, go to IDLE.
  - A response and the timeout in the same cycle: the response wins and `timeout_cnt` is unchanged.
- `db_rsp_valid` outside WAIT is ignored. This covers late responses arriving after a timeout.
- At most one transaction is outstanding; queue order is preserved.
- `out_valid` is high for exactly one cycle per popped entry. `out_flag` holds its value until the next reply.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - Outputs: `out_valid`=0, `out_flag`=0, `db_req_valid`=0, `db_req_key`=0, `db_req_flag`=0, `drop_cnt`=0, `timeout_cnt`=0, `busy`=0.
  - Internal: FSM=IDLE, pointers=0, count=0, timer=0.
  - FIFO storage is not reset.
- Reset mid-transaction aborts it; no `out_valid` is produced for the aborted or queued entries.
- Latency, for an empty queue in IDLE with `in_valid` in cycle t:
  - Entry is visible in t+1.
  - REQ is entered and `db_req_valid`=1 in t+2.
  - With `db_req_ready`=1 in t+2, WAIT starts in t+3.
  - A response in cycle r gives `out_valid`=1 in r+1.
- Back-to-back requests: the next entry leaves IDLE in the cycle after `out_valid`. The minimum spacing between `db_req_valid` rising edges is 4 cycles.
- Timeout: with no response, `out_valid` is asserted exactly TIMEOUT cycles after the first WAIT cycle.
- `busy` is combinational from count and state.

## Test plan
- Single request: key=96'h0A000001_0A000002_0035_0000, flag=4'b0101, `db_req_ready`=1, response flag 4'b0100 three cycles into WAIT -> `db_req_valid` in t+2 with matching key/flag, `out_valid` one cycle with `out_flag`=4'b0100, `busy` returns to 0.
- Backpressure: `db_req_ready`=0 for 10 cycles -> `db_req_valid` held and key/flag stable for all 10 cycles; WAIT is entered only after ready.
- Overflow: DEPTH=8 with `db_req_ready`=0, 10 pulses -> 8 queued, `drop_cnt`=2; after draining, 8 replies arrive in push order.
- Timeout: TIMEOUT=16 with no response -> `out_valid` 16 cycles after WAIT entry with `out_flag`=0, `timeout_cnt`=1; a late response is ignored and the next entry proceeds.
- Collision: response in the timeout cycle -> `out_flag`=response flag, `timeout_cnt` unchanged. Push while full in the same cycle as a pop -> accepted, `drop_cnt` unchanged.
- Reset in WAIT with 3 entries queued -> all outputs 0 immediately; no `out_valid` after release; a response during reset is ignored.
